cache_refill_ctrl: RTL and testbench
====================================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Param IDX_W, 8, cache index width; 256 sets, matches dirty table depth.
REQ-002 Param TAG_W, 20, tag width; TAG_W+IDX_W+4 SHALL equal 32 (16-byte line, 4 x 32-bit words).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 miss_valid_i / miss_ready_o  in/out  1  miss request handshake.
REQ-006 miss_index_i  in  IDX_W  missing set; miss_tag_i  in  TAG_W  new tag; victim_tag_i  in  TAG_W  evicted tag.
REQ-007 set_dirty_i  in  1  write-hit mark request; set_index_i  in  IDX_W  its set.
REQ-008 dirty_index_o  out  IDX_W; dirty_wr_en_o  out  1; dirty_wr_dirty_o  out  1; dirty_rd_i  in  1 (dirty table port, read data one cycle after index).
REQ-009 line_rd_en_o  out  1; line_wr_en_o  out  1; line_word_o  out  2; line_wdata_o  out  32; line_rdata_i  in  32 (data RAM, read latency 1).
REQ-010 mem_req_valid_o  out  1; mem_req_ready_i  in  1; mem_we_o  out  1; mem_addr_o  out  32; mem_wdata_o  out  32.
REQ-011 mem_rvalid_i  in  1; mem_rdata_i  in  32 (read response).
REQ-012 done_o  out  1  one-cycle pulse, refill complete.

Function
REQ-013 States SHALL be IDLE, CHK, WB_RD, WB_LD, WB_REQ, RF_REQ, RF_WAIT, FIN; 2-bit word counter wcnt.
REQ-014 IDLE: miss_ready_o = !set_dirty_i; all other strobes low except as in REQ-015.
REQ-015 IDLE with set_dirty_i=1: dirty_wr_en_o=1, dirty_wr_dirty_o=1, dirty_index_o=set_index_i; miss not accepted that cycle (set wins).
REQ-016 IDLE otherwise: dirty_index_o=miss_index_i; outside IDLE dirty_index_o=latched index.
REQ-017 Accept on miss_valid_i & miss_ready_o: latch index, miss_tag, victim_tag; wcnt<=0; go CHK.
REQ-018 CHK (1 cycle): dirty_rd_i=1 -> WB_RD; dirty_rd_i=0 -> RF_REQ.
REQ-019 WB_RD: line_rd_en_o=1, line_word_o=wcnt; next WB_LD.
REQ-020 WB_LD: mem_wdata_o register <= line_rdata_i; next WB_REQ.
REQ-021 WB_REQ: mem_req_valid_o=1, mem_we_o=1, mem_addr_o={victim_tag,index,wcnt,2'b00}; address/data held stable until mem_req_ready_i.
REQ-022 WB_REQ handshake: wcnt=3 -> wcnt<=0, RF_REQ; else wcnt++, WB_RD.
REQ-023 RF_REQ: mem_req_valid_o=1, mem_we_o=0, mem_addr_o={miss_tag,index,wcnt,2'b00}; handshake -> RF_WAIT.
REQ-024 RF_WAIT: on mem_rvalid_i, same cycle line_wr_en_o=1, line_word_o=wcnt, line_wdata_o=mem_rdata_i; wcnt=3 -> FIN, else wcnt++, RF_REQ.
REQ-025 mem_rvalid_i outside RF_WAIT SHALL be ignored; at most one memory request outstanding.
REQ-026 FIN (1 cycle): dirty_wr_en_o=1, dirty_wr_dirty_o=0, done_o=1; next IDLE.
REQ-027 set_dirty_i outside IDLE SHALL be ignored (requester holds it).
REQ-028 wcnt wraps 3->0 only via REQ-022/REQ-024 transitions.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, wcnt=0, all latched fields and mem_wdata_o=0, all strobes/valids/done_o low; mid-operation reset abandons transfer with no further memory or RAM writes.

Verification
REQ-030 Clean miss idx=0x12, tag=0xABCDE, dirty=0 -> 4 reads at 0xABCDE120/124/128/12C, 4 line writes, dirty write 0 at 0x12, done_o one pulse; no mem_we_o.
REQ-031 Dirty miss idx=0x05, victim=0x00001, RAM words 0x11..0x44 -> writes 0x11,0x22,0x33,0x44 to 0x00001050..5C before any read request.
REQ-032 mem_req_ready_i low 3 cycles in WB_REQ and RF_REQ -> addr/wdata/valid stable throughout, no skipped word.
REQ-033 set_dirty_i and miss_valid_i same IDLE cycle -> dirty write 1 to set_index_i, miss_ready_o=0, miss accepted next cycle.
REQ-034 rst_n low during RF_WAIT after 2 words -> outputs low same cycle, IDLE after release, spurious mem_rvalid_i causes no line write.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: services one cache miss at a time. A dirty victim line is
// first written back word by word (read data RAM, load write buffer, issue
// memory write), then the new line is fetched word by word (issue memory read,
// wait for response, write data RAM). The dirty table is cleared on completion.
// Write-hit dirty marks are accepted only while idle and take priority over a
// new miss in the same cycle.
//
// Handshake semantics: a transfer on miss_valid_i/miss_ready_o or on
// mem_req_valid_o/mem_req_ready_i happens on a rising edge where both are 1;
// while valid is high and ready is low, the requester holds every payload
// field stable. At most one memory request is outstanding.
//
// Address layout: {tag, index, word[1:0], 2'b00}, so TAG_W + IDX_W + 4 must be 32.
module cache_refill_ctrl #(
    parameter int IDX_W = 8,
    parameter int TAG_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             miss_valid_i,
    output logic             miss_ready_o,
    input  logic [IDX_W-1:0] miss_index_i,
    input  logic [TAG_W-1:0] miss_tag_i,
    input  logic [TAG_W-1:0] victim_tag_i,
    input  logic             set_dirty_i,
    input  logic [IDX_W-1:0] set_index_i,
    output logic [IDX_W-1:0] dirty_index_o,
    output logic             dirty_wr_en_o,
    output logic             dirty_wr_dirty_o,
    input  logic             dirty_rd_i,
    output logic             line_rd_en_o,
    output logic             line_wr_en_o,
    output logic [1:0]       line_word_o,
    output logic [31:0]      line_wdata_o,
    input  logic [31:0]      line_rdata_i,
    output logic             mem_req_valid_o,
    input  logic             mem_req_ready_i,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i,
    output logic             done_o,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHK     = 3'd1,
        WB_RD   = 3'd2,
        WB_LD   = 3'd3,
        WB_REQ  = 3'd4,
        RF_REQ  = 3'd5,
        RF_WAIT = 3'd6,
        FIN     = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_wcnt;
    logic [1:0]         w_wcnt_nxt;
    logic [IDX_W-1:0]   r_index;
    logic [TAG_W-1:0]   r_miss_tag;
    logic [TAG_W-1:0]   r_victim_tag;
    logic [31:0]        r_wdata;
    logic               w_accept;

    assign mem_wdata_o = r_wdata;
    assign dbg_state_o = r_state;

    // State, word counter, latched miss fields and write-back data buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wcnt       <= 2'd0;
            r_index      <= '0;
            r_miss_tag   <= '0;
            r_victim_tag <= '0;
            r_wdata      <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_accept) begin
                r_index      <= miss_index_i;
                r_miss_tag   <= miss_tag_i;
                r_victim_tag <= victim_tag_i;
            end
            if (r_state == WB_LD) begin
                r_wdata <= line_rdata_i;
            end
        end
    end

    // Next-state, counter update and all strobes, decoded from the current state.
    always_comb begin
        w_state_nxt      = r_state;
        w_wcnt_nxt       = r_wcnt;
        w_accept         = 1'b0;
        miss_ready_o     = 1'b0;
        dirty_index_o    = r_index;
        dirty_wr_en_o    = 1'b0;
        dirty_wr_dirty_o = 1'b0;
        line_rd_en_o     = 1'b0;
        line_wr_en_o     = 1'b0;
        line_word_o      = r_wcnt;
        line_wdata_o     = 32'd0;
        mem_req_valid_o  = 1'b0;
        mem_we_o         = 1'b0;
        mem_addr_o       = 32'd0;
        done_o           = 1'b0;

        case (r_state)
            IDLE: begin
                miss_ready_o = !set_dirty_i;
                if (set_dirty_i) begin
                    // A dirty mark wins the table port; the miss waits a cycle.
                    dirty_wr_en_o    = 1'b1;
                    dirty_wr_dirty_o = 1'b1;
                    dirty_index_o    = set_index_i;
                end else begin
                    // Present the miss index so the dirty bit is ready in CHK.
                    dirty_index_o = miss_index_i;
                    if (miss_valid_i) begin
                        w_accept    = 1'b1;
                        w_wcnt_nxt  = 2'd0;
                        w_state_nxt = CHK;
                    end
                end
            end
            CHK: begin
                w_state_nxt = dirty_rd_i ? WB_RD : RF_REQ;
            end
            WB_RD: begin
                line_rd_en_o = 1'b1;
                w_state_nxt  = WB_LD;
            end
            WB_LD: begin
                w_state_nxt = WB_REQ;
            end
            WB_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_we_o        = 1'b1;
                mem_addr_o      = {r_victim_tag, r_index, r_wcnt, 2'b00};
                if (mem_req_ready_i) begin
                    w_wcnt_nxt  = r_wcnt + 2'd1;
                    w_state_nxt = (r_wcnt == 2'd3) ? RF_REQ : WB_RD;
                end
            end
            RF_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_addr_o      = {r_miss_tag, r_index, r_wcnt, 2'b00};
                if (mem_req_ready_i) begin
                    w_state_nxt = RF_WAIT;
                end
            end
            RF_WAIT: begin
                if (mem_rvalid_i) begin
                    line_wr_en_o = 1'b1;
                    line_wdata_o = mem_rdata_i;
                    w_wcnt_nxt   = r_wcnt + 2'd1;
                    w_state_nxt  = (r_wcnt == 2'd3) ? FIN : RF_REQ;
                end
            end
            FIN: begin
                dirty_wr_en_o = 1'b1;
                done_o        = 1'b1;
                w_state_nxt   = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

    localparam int IDX_W = 8;
    localparam int TAG_W = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             miss_valid_i, miss_ready_o;
    logic [IDX_W-1:0] miss_index_i;
    logic [TAG_W-1:0] miss_tag_i, victim_tag_i;
    logic             set_dirty_i;
    logic [IDX_W-1:0] set_index_i, dirty_index_o;
    logic             dirty_wr_en_o, dirty_wr_dirty_o, dirty_rd_i;
    logic             line_rd_en_o, line_wr_en_o;
    logic [1:0]       line_word_o;
    logic [31:0]      line_wdata_o, line_rdata_i;
    logic             mem_req_valid_o, mem_req_ready_i, mem_we_o;
    logic [31:0]      mem_addr_o, mem_wdata_o;
    logic             mem_rvalid_i;
    logic [31:0]      mem_rdata_i;
    logic             done_o;
    logic [2:0]       dbg_state_o;

    cache_refill_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
        .miss_index_i(miss_index_i), .miss_tag_i(miss_tag_i), .victim_tag_i(victim_tag_i),
        .set_dirty_i(set_dirty_i), .set_index_i(set_index_i),
        .dirty_index_o(dirty_index_o), .dirty_wr_en_o(dirty_wr_en_o),
        .dirty_wr_dirty_o(dirty_wr_dirty_o), .dirty_rd_i(dirty_rd_i),
        .line_rd_en_o(line_rd_en_o), .line_wr_en_o(line_wr_en_o),
        .line_word_o(line_word_o), .line_wdata_o(line_wdata_o), .line_rdata_i(line_rdata_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .done_o(done_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    logic [64:0] exp_mem_q[$];    // {we, addr, wdata}
    logic [41:0] exp_line_q[$];   // {index, word, data}
    logic [8:0]  exp_dirty_q[$];  // {index, value}
    int n_checks = 0;
    int n_errors = 0;
    int exp_done = 0;
    int done_seen = 0;

    // Reference model of table/RAM contents (what they must hold after each miss).
    logic [31:0] ref_ram [256][4];
    logic        ref_dirty [256];

    // Environment knobs, written only by the main stimulus block.
    int ready_pct = 100;
    bit stall3 = 0;
    int rv_fixed = -1;
    int spur_req = 0;

    function automatic logic [31:0] ram_init(input int i, input int w);
        logic [31:0] v;
        if (i == 5) return 32'h11 * 32'(w + 1);
        v = 32'(i) * 32'h0100_0193 + 32'(w) * 32'h9E37_79B1;
        return v ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- environment: dirty table, data RAM, memory slave ----------------
    initial begin : env
        logic [31:0] env_ram [256][4];
        logic        env_dirty [256];
        logic [7:0]  s_didx;
        logic        s_dwe, s_dval, s_rd, s_wr, s_hs, s_we, s_valid;
        logic [1:0]  s_word;
        logic [31:0] s_wdat, s_addr, paddr;
        bit          pend;
        int          pcnt, sc, spur_done;
        for (int i = 0; i < 256; i++) begin
            env_dirty[i] = 1'b0;
            for (int w = 0; w < 4; w++) env_ram[i][w] = ram_init(i, w);
        end
        pend = 0; pcnt = 0; sc = 0; spur_done = 0; paddr = 0;
        dirty_rd_i = 0; line_rdata_i = 0; mem_req_ready_i = 0;
        mem_rvalid_i = 0; mem_rdata_i = 0;
        forever begin
            @(negedge clk);
            s_didx = dirty_index_o; s_dwe = dirty_wr_en_o; s_dval = dirty_wr_dirty_o;
            s_rd = line_rd_en_o; s_wr = line_wr_en_o; s_word = line_word_o; s_wdat = line_wdata_o;
            s_valid = mem_req_valid_o; s_hs = mem_req_valid_o && mem_req_ready_i;
            s_we = mem_we_o; s_addr = mem_addr_o;
            @(posedge clk);
            #1;
            dirty_rd_i = env_dirty[s_didx];
            if (s_dwe) env_dirty[s_didx] = s_dval;
            if (s_rd) line_rdata_i = env_ram[s_didx][s_word];
            if (s_wr) env_ram[s_didx][s_word] = s_wdat;
            if (s_hs && !s_we) begin
                pend = 1;
                paddr = s_addr;
                pcnt = (rv_fixed >= 0) ? rv_fixed : $urandom_range(0, 3);
            end
            mem_rvalid_i = 0;
            if (pend) begin
                if (pcnt == 0) begin
                    mem_rvalid_i = 1;
                    mem_rdata_i = rd_fn(paddr);
                    pend = 0;
                end else begin
                    pcnt--;
                end
            end else if (spur_done < spur_req) begin
                mem_rvalid_i = 1;
                mem_rdata_i = $urandom;
                spur_done++;
            end
            if (stall3) begin
                if (s_valid && !s_hs) sc++;
                if (s_hs) sc = 0;
                mem_req_ready_i = (sc >= 3);
            end else begin
                sc = 0;
                mem_req_ready_i = ($urandom_range(1, 100) <= ready_pct);
            end
        end
    end

    // ---------------- monitor: pops and compares on every DUT output event ----------------
    initial begin : monitor
        bit          prev_wait;
        logic [31:0] prev_addr, prev_wdata;
        logic        prev_we;
        logic [64:0] em;
        logic [41:0] el;
        logic [8:0]  ed;
        prev_wait = 0; prev_addr = 0; prev_wdata = 0; prev_we = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_wait = 0;
            end else begin
                if (prev_wait) begin
                    chk("stall_valid_held", 64'(mem_req_valid_o), 64'd1);
                    chk("stall_addr_held", 64'(mem_addr_o), 64'(prev_addr));
                    chk("stall_we_held", 64'(mem_we_o), 64'(prev_we));
                    if (prev_we) chk("stall_wdata_held", 64'(mem_wdata_o), 64'(prev_wdata));
                end
                prev_wait = mem_req_valid_o && !mem_req_ready_i;
                prev_addr = mem_addr_o; prev_we = mem_we_o; prev_wdata = mem_wdata_o;
                if (mem_req_valid_o && mem_req_ready_i) begin
                    if (exp_mem_q.size() == 0) begin
                        chk("mem_req_unexpected", 64'(mem_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        em = exp_mem_q.pop_front();
                        chk("mem_we", 64'(mem_we_o), 64'(em[64]));
                        chk("mem_addr", 64'(mem_addr_o), 64'(em[63:32]));
                        if (em[64]) chk("mem_wdata", 64'(mem_wdata_o), 64'(em[31:0]));
                    end
                end
                if (line_wr_en_o) begin
                    if (exp_line_q.size() == 0) begin
                        chk("line_wr_unexpected", 64'(line_wdata_o), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        el = exp_line_q.pop_front();
                        chk("line_wr", 64'({dirty_index_o, line_word_o, line_wdata_o}), 64'(el));
                    end
                end
                if (dirty_wr_en_o) begin
                    if (exp_dirty_q.size() == 0) begin
                        chk("dirty_wr_unexpected", 64'(dirty_index_o), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        ed = exp_dirty_q.pop_front();
                        chk("dirty_wr", 64'({dirty_index_o, dirty_wr_dirty_o}), 64'(ed));
                    end
                end
                if (done_o) done_seen++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_dirty_only(input logic [7:0] sidx);
        ref_dirty[sidx] = 1'b1;
        exp_dirty_q.push_back({sidx, 1'b1});
        set_dirty_i = 1; set_index_i = sidx;
        miss_valid_i = 0;
        @(negedge clk);
        chk("set_ready_low", 64'(miss_ready_o), 64'd0);
        @(posedge clk);
        #1;
        set_dirty_i = 0;
    endtask

    task automatic do_miss(input logic [7:0] idx, input logic [19:0] tag, input logic [19:0] vt,
                           input bit with_set, input logic [7:0] sidx, input bit abort_mid);
        logic [31:0] a;
        logic [31:0] saved [4];
        logic        old_dirty;
        bit          acc;
        int          n, rdc;
        if (with_set) begin
            ref_dirty[sidx] = 1'b1;
            exp_dirty_q.push_back({sidx, 1'b1});
        end
        old_dirty = ref_dirty[idx];
        for (int w = 0; w < 4; w++) saved[w] = ref_ram[idx][w];
        if (ref_dirty[idx]) begin
            for (int w = 0; w < 4; w++) begin
                a = {vt, idx, 2'(w), 2'b00};
                exp_mem_q.push_back({1'b1, a, ref_ram[idx][w]});
            end
        end
        for (int w = 0; w < 4; w++) begin
            a = {tag, idx, 2'(w), 2'b00};
            exp_mem_q.push_back({1'b0, a, 32'd0});
            exp_line_q.push_back({idx, 2'(w), rd_fn(a)});
            ref_ram[idx][w] = rd_fn(a);
        end
        exp_dirty_q.push_back({idx, 1'b0});
        ref_dirty[idx] = 1'b0;
        exp_done++;

        miss_valid_i = 1; miss_index_i = idx; miss_tag_i = tag; victim_tag_i = vt;
        if (with_set) begin
            set_dirty_i = 1; set_index_i = sidx;
            @(negedge clk);
            chk("set_blocks_miss", 64'(miss_ready_o), 64'd0);
            @(posedge clk);
            #1;
            set_dirty_i = 0;
        end
        acc = 0; n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = miss_ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        miss_valid_i = 0;
        miss_tag_i = $urandom; victim_tag_i = $urandom; miss_index_i = $urandom;
        chk("miss_accepted", 64'(acc), 64'd1);

        if (abort_mid) begin
            rdc = 0; n = 0;
            while (rdc < 3 && n < 400) begin
                @(negedge clk);
                if (mem_req_valid_o && mem_req_ready_i && !mem_we_o) rdc++;
                n++;
            end
            chk("abort_third_read", 64'(rdc), 64'd3);
            @(posedge clk);
            #1;
            rst_n = 0;
            #1;
            chk("rst_mem_valid", 64'(mem_req_valid_o), 64'd0);
            chk("rst_line_wr", 64'(line_wr_en_o), 64'd0);
            chk("rst_dirty_wr", 64'(dirty_wr_en_o), 64'd0);
            chk("rst_done", 64'(done_o), 64'd0);
            chk("rst_wdata", 64'(mem_wdata_o), 64'd0);
            chk("rst_addr", 64'(mem_addr_o), 64'd0);
            exp_mem_q.delete(); exp_line_q.delete(); exp_dirty_q.delete();
            exp_done--;
            ref_ram[idx][2] = saved[2];
            ref_ram[idx][3] = saved[3];
            ref_dirty[idx] = old_dirty;
            spur_req += 3;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                chk("no_line_wr_after_rst", 64'(line_wr_en_o), 64'd0);
                chk("idle_after_rst", 64'(miss_ready_o), 64'd1);
            end
            @(posedge clk);
            #1;
        end else begin
            n = 0;
            acc = 0;
            while (!acc && n < 600) begin
                @(negedge clk);
                acc = done_o;
                n++;
            end
            chk("done_reached", 64'(acc), 64'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic random_ops(input int count);
        logic [7:0] idx, sidx;
        for (int k = 0; k < count; k++) begin
            ready_pct = $urandom_range(40, 100);
            idx = 8'($urandom_range(0, 31));
            sidx = 8'($urandom_range(0, 31));
            case ($urandom_range(0, 9))
                0, 1, 2: set_dirty_only(sidx);
                3, 4:    do_miss(idx, 20'($urandom), 20'($urandom), 1'b1, sidx, 1'b0);
                default: do_miss(idx, 20'($urandom), 20'($urandom), 1'b0, 8'd0, 1'b0);
            endcase
        end
    endtask

    // ---------------- main stimulus ----------------
    initial begin : main
        int n;
        for (int i = 0; i < 256; i++) begin
            ref_dirty[i] = 1'b0;
            for (int w = 0; w < 4; w++) ref_ram[i][w] = ram_init(i, w);
        end
        miss_valid_i = 0; miss_index_i = 0; miss_tag_i = 0; victim_tag_i = 0;
        set_dirty_i = 0; set_index_i = 0;
        rst_n = 1;
        #2;
        rst_n = 0;
        #1;
        chk("reset_ready", 64'(miss_ready_o), 64'd1);
        chk("reset_mem_valid", 64'(mem_req_valid_o), 64'd0);
        chk("reset_line_rd", 64'(line_rd_en_o), 64'd0);
        chk("reset_line_wr", 64'(line_wr_en_o), 64'd0);
        chk("reset_dirty_wr", 64'(dirty_wr_en_o), 64'd0);
        chk("reset_done", 64'(done_o), 64'd0);
        chk("reset_wdata", 64'(mem_wdata_o), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;

        // Clean miss: four reads at 0xABCDE120..12C, no writes.
        do_miss(8'h12, 20'hABCDE, 20'h0F0F0, 1'b0, 8'd0, 1'b0);
        // Dirty miss: write-back 0x11..0x44 to 0x00001050..5C first.
        set_dirty_only(8'h05);
        do_miss(8'h05, 20'h7E57A, 20'h00001, 1'b0, 8'd0, 1'b0);
        // Three-cycle ready stalls on every write and read request.
        stall3 = 1;
        set_dirty_only(8'h09);
        do_miss(8'h09, 20'h13579, 20'h2468A, 1'b0, 8'd0, 1'b0);
        stall3 = 0;
        // Dirty mark and miss in the same idle cycle.
        do_miss(8'h20, 20'h0C0DE, 20'h0BEEF, 1'b1, 8'h33, 1'b0);
        do_miss(8'h33, 20'h55555, 20'hAAAAA, 1'b1, 8'h33, 1'b0);

        random_ops(24);

        // Reset in RF_WAIT after two refill words; late and spurious responses follow.
        ready_pct = 100;
        rv_fixed = 3;
        do_miss(8'h77, 20'h3C3C3, 20'h11111, 1'b0, 8'd0, 1'b1);
        rv_fixed = -1;

        random_ops(8);

        n = 0;
        while ((exp_mem_q.size() + exp_line_q.size() + exp_dirty_q.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mem_q_drained", 64'(exp_mem_q.size()), 64'd0);
        chk("line_q_drained", 64'(exp_line_q.size()), 64'd0);
        chk("dirty_q_drained", 64'(exp_dirty_q.size()), 64'd0);
        chk("done_count", 64'(done_seen), 64'(exp_done));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound.
    initial begin : watchdog
        #2000000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
